// File: rtl/fm_backward_search.sv
// FM-index backward search over a 2-bit DNA read, one Occ ROM lookup per base.
// Narrows the suffix-array interval [k,l] from the last base down to the first.
//
// state  | meaning
// IDLE   | waiting for start; result outputs hold the last search
// LOOKUP | Occ ROM addressed at rows k-1 and l, lane for current base latched
// UPDATE | new interval computed; miss ends early, else next base or finish
// DONE   | one-cycle done pulse, then back to IDLE
module fm_backward_search #(
    parameter logic [7:0] REF_LEN = 8'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] read_seq,
    input  logic [4:0]  read_len,
    input  logic [7:0]  c_a,
    input  logic [7:0]  c_c,
    input  logic [7:0]  c_g,
    input  logic [7:0]  c_t,
    output logic        occ_ce,
    output logic [7:0]  occ_addr_1,
    output logic [7:0]  occ_addr_2,
    input  logic [31:0] occ_data_1,
    input  logic [31:0] occ_data_2,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [7:0]  k_out,
    output logic [7:0]  l_out
);

    typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, DONE} state_t;

    state_t      state_q;
    logic [31:0] seq_q;
    logic [7:0]  c_a_q, c_c_q, c_g_q, c_t_q;
    logic [3:0]  idx_q;
    logic [7:0]  occ_k_q, occ_l_q;
    logic        occ_ce_q, busy_q, done_q, found_q;
    logic [7:0]  addr_1_q, addr_2_q, k_out_q, l_out_q;

    logic [4:0]  len_sat;
    logic [4:0]  len_m1;
    logic [1:0]  base;
    logic [7:0]  c_base;
    logic [7:0]  lane_1, lane_2;
    logic [8:0]  k_d, l_d;

    assign len_sat = (read_len > 5'd16) ? 5'd16 : read_len;
    assign len_m1  = len_sat - 5'd1;
    assign base    = seq_q[{idx_q, 1'b0} +: 2];
    assign lane_1  = occ_data_1[{base, 3'b000} +: 8];
    assign lane_2  = occ_data_2[{base, 3'b000} +: 8];

    always_comb begin
        c_base = c_a_q;
        case (base)
            2'd0: c_base = c_a_q;
            2'd1: c_base = c_c_q;
            2'd2: c_base = c_g_q;
            2'd3: c_base = c_t_q;
            default: c_base = c_a_q;
        endcase
    end

    // 9-bit sums so a wrap past 255 still reads as an empty interval
    assign k_d = {1'b0, c_base} + {1'b0, occ_k_q} + 9'd1;
    assign l_d = {1'b0, c_base} + {1'b0, occ_l_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            seq_q    <= '0;
            c_a_q    <= '0;
            c_c_q    <= '0;
            c_g_q    <= '0;
            c_t_q    <= '0;
            idx_q    <= '0;
            occ_k_q  <= '0;
            occ_l_q  <= '0;
            occ_ce_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            addr_1_q <= '0;
            addr_2_q <= '0;
            k_out_q  <= '0;
            l_out_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        seq_q <= read_seq;
                        c_a_q <= c_a;
                        c_c_q <= c_c;
                        c_g_q <= c_g;
                        c_t_q <= c_t;
                        if (len_sat == 5'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            found_q <= 1'b1;
                            k_out_q <= 8'd0;
                            l_out_q <= REF_LEN - 8'd1;
                        end else begin
                            state_q  <= LOOKUP;
                            busy_q   <= 1'b1;
                            idx_q    <= len_m1[3:0];
                            occ_ce_q <= 1'b1;
                            addr_1_q <= 8'hff;
                            addr_2_q <= REF_LEN - 8'd1;
                        end
                    end
                end
                LOOKUP: begin
                    occ_k_q  <= lane_1;
                    occ_l_q  <= lane_2;
                    occ_ce_q <= 1'b0;
                    state_q  <= UPDATE;
                end
                UPDATE: begin
                    if (k_d > l_d) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        found_q <= 1'b0;
                        k_out_q <= k_d[7:0];
                        l_out_q <= l_d[7:0];
                    end else if (idx_q == 4'd0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        found_q <= 1'b1;
                        k_out_q <= k_d[7:0];
                        l_out_q <= l_d[7:0];
                    end else begin
                        // address registers carry the stored interval: row k-1 and row l
                        state_q  <= LOOKUP;
                        idx_q    <= idx_q - 4'd1;
                        occ_ce_q <= 1'b1;
                        addr_1_q <= k_d[7:0] - 8'd1;
                        addr_2_q <= l_d[7:0];
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign occ_ce     = occ_ce_q;
    assign occ_addr_1 = addr_1_q;
    assign occ_addr_2 = addr_2_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign found      = found_q;
    assign k_out      = k_out_q;
    assign l_out      = l_out_q;

endmodule

// File: tb/tb_fm_backward_search.sv
// Directed bench for fm_backward_search against the "ACA$" Occ ROM.
// Checks latency, interval results, ignored start while busy and mid-search reset.
module tb_fm_backward_search;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] read_seq = '0;
    logic [4:0]  read_len = '0;
    logic [7:0]  c_a = 8'd0, c_c = 8'd2, c_g = 8'd3, c_t = 8'd3;
    logic        occ_ce;
    logic [7:0]  occ_addr_1, occ_addr_2;
    logic [31:0] occ_data_1, occ_data_2;
    logic        busy, done, found;
    logic [7:0]  k_out, l_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [7:0] a);
        case (a)
            8'd0:    rom = 32'h00000001;
            8'd1:    rom = 32'h00000101;
            8'd2:    rom = 32'h00000101;
            8'd3:    rom = 32'h00000102;
            default: rom = 32'h00000000;
        endcase
    endfunction

    assign occ_data_1 = rom(occ_addr_1);
    assign occ_data_2 = rom(occ_addr_2);

    fm_backward_search #(.REF_LEN(8'd4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .read_seq(read_seq), .read_len(read_len),
        .c_a(c_a), .c_c(c_c), .c_g(c_g), .c_t(c_t),
        .occ_ce(occ_ce), .occ_addr_1(occ_addr_1), .occ_addr_2(occ_addr_2),
        .occ_data_1(occ_data_1), .occ_data_2(occ_data_2),
        .busy(busy), .done(done), .found(found),
        .k_out(k_out), .l_out(l_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start edge is cycle 0; sampling happens 1 time unit after each rising edge.
    task automatic run(input string tag, input logic [31:0] seq, input logic [4:0] len,
                       input int exp_cyc, input logic exp_f, input logic [7:0] ek,
                       input logic [7:0] el, input bit mid_start);
        int cyc;
        bit got;
        @(negedge clk);
        read_seq = seq;
        read_len = len;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        got = 0;
        while (cyc <= 40 && !got) begin
            if (cyc == 1 && len != 5'd0) begin
                check({tag, "_ce_c1"}, occ_ce, 1'b1);
                check({tag, "_addr1_c1"}, occ_addr_1, 8'hff);
                check({tag, "_addr2_c1"}, occ_addr_2, 8'd3);
                check({tag, "_busy_c1"}, busy, 1'b1);
            end
            if (cyc == 2 && len != 5'd0)
                check({tag, "_ce_c2"}, occ_ce, 1'b0);
            if (mid_start && cyc == 2) begin
                read_seq = 32'h2;
                read_len = 5'd1;
                start = 1'b1;
            end
            if (mid_start && cyc == 3) start = 1'b0;
            if (done) got = 1;
            else begin
                @(posedge clk);
                #1 cyc++;
            end
        end
        check({tag, "_done_cycle"}, got ? cyc : 0, exp_cyc);
        check({tag, "_found"}, found, exp_f);
        check({tag, "_k"}, k_out, ek);
        check({tag, "_l"}, l_out, el);
        check({tag, "_busy_done"}, busy, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_k_hold"}, k_out, ek);
        if (mid_start) begin
            repeat (4) @(posedge clk);
            #1 check({tag, "_no_restart"}, busy, 1'b0);
        end
    endtask

    initial begin
        bit saw_done;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ce", occ_ce, 1'b0);
        check("rst_addr1", occ_addr_1, 8'h00);
        check("rst_k", k_out, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);

        run("A",   32'h0, 5'd1, 3, 1'b1, 8'd1, 8'd2, 0);
        run("CA",  32'h1, 5'd2, 5, 1'b1, 8'd3, 8'd3, 0);
        run("G",   32'h2, 5'd1, 3, 1'b0, 8'd4, 8'd3, 0);
        run("AA",  32'h0, 5'd2, 5, 1'b0, 8'd2, 8'd1, 0);
        run("L0",  32'h3, 5'd0, 1, 1'b1, 8'd0, 8'd3, 0);
        run("CAx", 32'h1, 5'd2, 5, 1'b1, 8'd3, 8'd3, 1);

        // reset during cycle 2 of a search
        @(negedge clk);
        read_seq = 32'h1;
        read_len = 5'd2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_busy", busy, 1'b0);
        check("mrst_found", found, 1'b0);
        check("mrst_k", k_out, 8'd0);
        check("mrst_l", l_out, 8'd0);
        check("mrst_ce", occ_ce, 1'b0);
        check("mrst_addr2", occ_addr_2, 8'd0);
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 if (done) saw_done = 1;
        end
        check("mrst_no_done", saw_done, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        run("A_after_rst", 32'h0, 5'd1, 3, 1'b1, 8'd1, 8'd2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
